// File: rtl/mc_control.sv
// Multi-cycle control unit: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB (plus MDWAIT for multu/div) and drives the
// datapath selects, write strobes and a retired-instruction counter.
module mc_control #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 16,
  parameter int RET_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic             c1,
  output logic             c2,
  output logic             c3,
  output logic             c4,
  output logic [2:0]       cA,
  output logic [1:0]       cB,
  output logic [1:0]       cmul,
  output logic             dmem_we,
  output logic             reg_we,
  output logic             md_busy,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [RET_W-1:0] retired
);

  localparam int MD_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W  = $clog2(MD_MAX + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MDWAIT = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CL_RES, CL_LUI, CL_ADDIU, CL_ADD, CL_LW, CL_SW,
    CL_BEQ, CL_J, CL_MULTU, CL_DIV
  } class_e;

  state_e            stateQ, stateD;
  class_e            classQ, classD, decClass;
  logic [CNT_W-1:0]  cntQ, cntD;
  logic [RET_W-1:0]  retQ;

  // Classify the instruction currently presented by the IR.
  always_comb begin
    decClass = CL_RES;
    case (opcode)
      6'b000000: begin
        case (func)
          6'b100000: decClass = CL_ADD;
          6'b011001: decClass = CL_MULTU;
          6'b011010: decClass = CL_DIV;
          default:   decClass = CL_RES;
        endcase
      end
      6'b001111: decClass = CL_LUI;
      6'b001001: decClass = CL_ADDIU;
      6'b100011: decClass = CL_LW;
      6'b101011: decClass = CL_SW;
      6'b000100: decClass = CL_BEQ;
      6'b000010: decClass = CL_J;
      default:   decClass = CL_RES;
    endcase
  end

  // State, class, wait counter and retired counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= S_FETCH;
      classQ <= CL_RES;
      cntQ   <= '0;
      retQ   <= '0;
    end else begin
      stateQ <= stateD;
      classQ <= classD;
      cntQ   <= cntD;
      if (pc_we) retQ <= retQ + 1'b1;
    end
  end

  // Next-state logic; the class is captured only in DECODE.
  always_comb begin
    stateD = stateQ;
    classD = classQ;
    cntD   = cntQ;
    case (stateQ)
      S_FETCH: if (mem_ready) stateD = S_DECODE;
      S_DECODE: begin
        classD = decClass;
        case (decClass)
          CL_J, CL_RES: stateD = S_FETCH;
          CL_MULTU: begin
            cntD   = CNT_W'(MUL_CYCLES);
            stateD = S_MDWAIT;
          end
          CL_DIV: begin
            cntD   = CNT_W'(DIV_CYCLES);
            stateD = S_MDWAIT;
          end
          default: stateD = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (classQ)
          CL_LW, CL_SW:              stateD = S_MEM;
          CL_LUI, CL_ADDIU, CL_ADD:  stateD = S_WB;
          default:                   stateD = S_FETCH;
        endcase
      end
      S_MEM: if (mem_ready) stateD = (classQ == CL_LW) ? S_WB : S_FETCH;
      S_WB: stateD = S_FETCH;
      S_MDWAIT: begin
        cntD = cntQ - 1'b1;
        if (cntQ == CNT_W'(1)) stateD = S_FETCH;
      end
      default: stateD = S_FETCH;
    endcase
  end

  // Strobes and next-PC select; forced low while reset is asserted.
  always_comb begin
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    dmem_we = 1'b0;
    reg_we  = 1'b0;
    md_busy = 1'b0;
    illegal = 1'b0;
    cB      = 2'b00;
    if (rst_n) begin
      case (stateQ)
        S_FETCH: ir_we = mem_ready;
        S_DECODE: begin
          if (decClass == CL_J) begin
            pc_we = 1'b1;
            cB    = 2'b10;
          end else if (decClass == CL_RES) begin
            pc_we   = 1'b1;
            illegal = 1'b1;
          end
        end
        S_EXEC: begin
          if (classQ == CL_BEQ) begin
            pc_we = 1'b1;
            cB    = zero ? 2'b01 : 2'b00;
          end
        end
        S_MEM: begin
          if (classQ == CL_SW) begin
            dmem_we = mem_ready;
            pc_we   = mem_ready;
          end
        end
        S_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
        end
        S_MDWAIT: begin
          md_busy = 1'b1;
          pc_we   = (cntQ == CNT_W'(1));
        end
        default: ;
      endcase
    end
  end

  // Datapath selects decoded from the latched class.
  always_comb begin
    c1   = (classQ == CL_LUI) || (classQ == CL_ADDIU) ||
           (classQ == CL_LW)  || (classQ == CL_SW);
    c2   = (classQ == CL_ADD);
    c3   = (classQ == CL_LUI);
    c4   = (classQ == CL_LW);
    cA   = 3'b000;
    cmul = 2'b00;
    case (classQ)
      CL_ADDIU, CL_LW, CL_SW: cA = 3'b010;
      CL_LUI:                 cA = 3'b001;
      CL_ADD:                 cA = 3'b100;
      default:                cA = 3'b000;
    endcase
    if (classQ == CL_MULTU) cmul = 2'b01;
    else if (classQ == CL_DIV) cmul = 2'b10;
  end

  assign state   = stateQ;
  assign retired = retQ;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: a table of single instructions with
// hand-computed latency/select/strobe expectations, plus hand-written
// sequences for memory stalls, mid-MDWAIT reset and retired wrap.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, func;
  logic       zero, mem_ready;
  logic       ir_we, pc_we, c1, c2, c3, c4, dmem_we, reg_we, md_busy, illegal;
  logic [2:0] cA, state;
  logic [1:0] cB, cmul;
  logic [3:0] retired;

  mc_control #(.MUL_CYCLES(4), .DIV_CYCLES(16), .RET_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we), .c1(c1), .c2(c2),
    .c3(c3), .c4(c4), .cA(cA), .cB(cB), .cmul(cmul), .dmem_we(dmem_we),
    .reg_we(reg_we), .md_busy(md_busy), .illegal(illegal), .state(state),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         lat;
    logic [3:0] sel;
    logic [2:0] aluOp;
    logic [1:0] pcSel;
    logic [1:0] mulSel;
    int         regN;
    int         dmemN;
    int         illN;
    int         mdN;
  } vec_t;

  vec_t vecs[$];

  int passCnt = 0;
  int totalCnt = 0;
  logic [3:0] expRet = 4'd0;

  int         latR, irN, regN, dmemN, illN, mdN, memCyc, cmulBad;
  logic       gotPc, mdAtPc;
  logic [1:0] cBR, cmulR;
  logic [2:0] cAR, stateAfter;
  logic [3:0] selR;
  logic [59:0] trace;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic addVec(input string n, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input int lat, input logic [3:0] sel,
                        input logic [2:0] aluOp, input logic [1:0] pcSel,
                        input logic [1:0] mulSel, input int rN, input int dN,
                        input int iN, input int mN);
    vec_t v;
    v.name = n; v.op = op; v.fn = fn; v.z = z; v.lat = lat; v.sel = sel;
    v.aluOp = aluOp; v.pcSel = pcSel; v.mulSel = mulSel; v.regN = rN;
    v.dmemN = dN; v.illN = iN; v.mdN = mN;
    vecs.push_back(v);
  endtask

  // Runs one instruction starting in FETCH until its pc_we cycle, then
  // spends one idle FETCH cycle capturing the latched selects.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z,
                               input int fetchStall, input int memStall,
                               input logic [1:0] expCmul);
    int cyc = 0;
    int fs = 0;
    int ms = 0;
    gotPc = 0; latR = 0; irN = 0; regN = 0; dmemN = 0; illN = 0; mdN = 0;
    memCyc = 0; cmulBad = 0; mdAtPc = 0; cBR = 2'b00; trace = '0;
    while (!gotPc && cyc < 60) begin
      @(negedge clk);
      opcode = op; func = fn; zero = z;
      if (state == 3'd0) begin
        mem_ready = (fs < fetchStall) ? 1'b0 : 1'b1;
        if (fs < fetchStall) fs++;
      end else if (state == 3'd3) begin
        mem_ready = (ms < memStall) ? 1'b0 : 1'b1;
        if (ms < memStall) ms++;
        memCyc++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      cyc++;
      trace = {trace[56:0], state};
      irN   += int'(ir_we);
      regN  += int'(reg_we);
      dmemN += int'(dmem_we);
      illN  += int'(illegal);
      mdN   += int'(md_busy);
      if (md_busy && cmul !== expCmul) cmulBad++;
      if (pc_we) begin
        gotPc  = 1;
        latR   = cyc;
        cBR    = cB;
        mdAtPc = md_busy;
      end
    end
    if (!gotPc) checkOutput("timeout waiting for pc_we", 64'd0, 64'd1);
    else expRet = expRet + 4'd1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    selR       = {c1, c2, c3, c4};
    cAR        = cA;
    cmulR      = cmul;
    stateAfter = state;
  endtask

  initial begin
    int waitCyc;
    rst_n = 1'b0; opcode = 6'b0; func = 6'b0; zero = 1'b0; mem_ready = 1'b1;

    // Vector table: name, op, fn, zero, latency, {c1,c2,c3,c4}, cA, cB, cmul,
    // reg_we cycles, dmem_we cycles, illegal pulses, md_busy cycles.
    addVec("lui",    6'b001111, 6'b000000, 1'b0,  4, 4'b1010, 3'b001, 2'b00, 2'b00, 1, 0, 0, 0);
    addVec("addiu",  6'b001001, 6'b000000, 1'b0,  4, 4'b1000, 3'b010, 2'b00, 2'b00, 1, 0, 0, 0);
    addVec("add",    6'b000000, 6'b100000, 1'b0,  4, 4'b0100, 3'b100, 2'b00, 2'b00, 1, 0, 0, 0);
    addVec("lw",     6'b100011, 6'b000000, 1'b0,  5, 4'b1001, 3'b010, 2'b00, 2'b00, 1, 0, 0, 0);
    addVec("sw",     6'b101011, 6'b000000, 1'b0,  4, 4'b1000, 3'b010, 2'b00, 2'b00, 0, 1, 0, 0);
    addVec("beq_t",  6'b000100, 6'b000000, 1'b1,  3, 4'b0000, 3'b000, 2'b01, 2'b00, 0, 0, 0, 0);
    addVec("beq_n",  6'b000100, 6'b000000, 1'b0,  3, 4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0);
    addVec("j",      6'b000010, 6'b000000, 1'b0,  2, 4'b0000, 3'b000, 2'b10, 2'b00, 0, 0, 0, 0);
    addVec("multu",  6'b000000, 6'b011001, 1'b0,  6, 4'b0000, 3'b000, 2'b00, 2'b01, 0, 0, 0, 4);
    addVec("div",    6'b000000, 6'b011010, 1'b0, 18, 4'b0000, 3'b000, 2'b00, 2'b10, 0, 0, 0, 16);
    addVec("resv",   6'b111111, 6'b000000, 1'b0,  2, 4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 1, 0);
    addVec("badfn",  6'b000000, 6'b000001, 1'b0,  2, 4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 1, 0);

    // Reset state with mem_ready high: ir_we must stay low too.
    @(negedge clk); #1;
    checkOutput("reset.state", 64'(state), 64'd0);
    checkOutput("reset.strobes", 64'({ir_we, pc_we, dmem_we, reg_we, illegal, md_busy}), 64'd0);
    checkOutput("reset.selects", 64'({c1, c2, c3, c4, cA, cB, cmul}), 64'd0);
    checkOutput("reset.retired", 64'(retired), 64'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].fn, vecs[i].z, 0, 0, vecs[i].mulSel);
      checkOutput({vecs[i].name, ".lat"},     64'(latR),  64'(vecs[i].lat));
      checkOutput({vecs[i].name, ".cB"},      64'(cBR),   64'(vecs[i].pcSel));
      checkOutput({vecs[i].name, ".reg_we"},  64'(regN),  64'(vecs[i].regN));
      checkOutput({vecs[i].name, ".dmem_we"}, 64'(dmemN), 64'(vecs[i].dmemN));
      checkOutput({vecs[i].name, ".illegal"}, 64'(illN),  64'(vecs[i].illN));
      checkOutput({vecs[i].name, ".md_busy"}, 64'(mdN),   64'(vecs[i].mdN));
      checkOutput({vecs[i].name, ".ir_we"},   64'(irN),   64'd1);
      checkOutput({vecs[i].name, ".sel"},     64'(selR),  64'(vecs[i].sel));
      checkOutput({vecs[i].name, ".cA"},      64'(cAR),   64'(vecs[i].aluOp));
      checkOutput({vecs[i].name, ".cmul"},    64'(cmulR), 64'(vecs[i].mulSel));
      checkOutput({vecs[i].name, ".state"},   64'(stateAfter), 64'd0);
      checkOutput({vecs[i].name, ".retired"}, 64'(retired), 64'(expRet));
      if (vecs[i].mdN > 0) begin
        checkOutput({vecs[i].name, ".cmulHeld"}, 64'(cmulBad), 64'd0);
        checkOutput({vecs[i].name, ".pcOnLastMd"}, 64'(mdAtPc), 64'd1);
      end
    end

    // add walks FETCH, DECODE, EXEC, WB.
    applyStimulus(6'b000000, 6'b100000, 1'b0, 0, 0, 2'b00);
    checkOutput("add.trace", 64'(trace[11:0]), 64'(12'b000_001_010_100));

    // lw with a 2-cycle fetch stall and a 3-cycle memory stall.
    applyStimulus(6'b100011, 6'b000000, 1'b0, 2, 3, 2'b00);
    checkOutput("lwStall.memCycles", 64'(memCyc), 64'd4);
    checkOutput("lwStall.lat", 64'(latR), 64'd10);
    checkOutput("lwStall.ir_we", 64'(irN), 64'd1);
    checkOutput("lwStall.reg_we", 64'(regN), 64'd1);
    checkOutput("lwStall.dmem_we", 64'(dmemN), 64'd0);
    checkOutput("lwStall.c4", 64'(selR[0]), 64'd1);
    checkOutput("lwStall.trace", 64'(trace[8:0]), 64'(9'b011_011_100));

    // sw with a 2-cycle memory stall still writes exactly once.
    applyStimulus(6'b101011, 6'b000000, 1'b0, 0, 2, 2'b00);
    checkOutput("swStall.dmem_we", 64'(dmemN), 64'd1);
    checkOutput("swStall.lat", 64'(latR), 64'd6);
    checkOutput("swStall.retired", 64'(retired), 64'(expRet));

    // Reset asserted in the middle of a div wait.
    @(negedge clk);
    opcode = 6'b000000; func = 6'b011010; mem_ready = 1'b1;
    waitCyc = 0;
    while (state != 3'd5 && waitCyc < 10) begin
      @(negedge clk);
      waitCyc++;
    end
    checkOutput("midReset.reachMdwait", 64'(state), 64'd5);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midReset.state", 64'(state), 64'd0);
    checkOutput("midReset.strobes", 64'({ir_we, pc_we, dmem_we, reg_we, illegal, md_busy}), 64'd0);
    checkOutput("midReset.selects", 64'({c1, c2, c3, c4, cA, cB, cmul}), 64'd0);
    checkOutput("midReset.retired", 64'(retired), 64'd0);
    expRet = 4'd0;
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;

    // Sixteen jumps wrap the 4-bit retired counter back to 0.
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(6'b000010, 6'b000000, 1'b0, 0, 0, 2'b00);
      if (k == 15) checkOutput("wrap.at15", 64'(retired), 64'd15);
      if (k == 16) checkOutput("wrap.at16", 64'(retired), 64'd0);
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
